// File: rtl/edge_event_arbiter_if.sv
// Event handshake between edge_event_arbiter (master) and its consumer (slave):
// one channel index per valid/ready transfer.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4
) ();
  localparam int CH_W = $clog2(N_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;

  modport master (output evt_valid, output evt_ch, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector with round-robin serialisation onto one valid/ready port.
// Optional sticky overflow flags: define EDGE_EVT_OVERFLOW_EN.
module edge_event_arbiter_lane (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  input  logic en_i,
  input  logic grant_i,
  input  logic ovf_clr_i,
  output logic pend_o,
  output logic ovf_o
);
  logic prev_q, pend_q, pend_d, edge_w;

  // prev tracks the input even while disabled, so re-enabling on a high level is not an edge
  assign edge_w = sig_i & ~prev_q & en_i;
  assign pend_d = en_i & (edge_w | (pend_q & ~grant_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

`ifdef EDGE_EVT_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // a fresh set beats a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (edge_w & pend_q & ~grant_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr_i;
  assign ovf_o          = 1'b0;
`endif
endmodule

module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      sig_in,
  input  logic [N_CH-1:0]      ch_en,
  output logic [N_CH-1:0]      pend,
  output logic [N_CH-1:0]      ovf,
  input  logic                 ovf_clr,
  edge_event_arbiter_if.master evt
);
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] rr_q, rr_d, ch_q, ch_d, win, hi_idx, lo_idx;
  logic            valid_q, valid_d, hi_found, lo_found, load;

  edge_event_arbiter_lane u_lane [N_CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (sig_in),
    .en_i     (ch_en),
    .grant_i  (grant),
    .ovf_clr_i(ovf_clr),
    .pend_o   (pend),
    .ovf_o    (ovf)
  );

  // Descending scan so the last hit is the lowest index: lo over all, hi at/above rr_q
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        lo_found = 1'b1;
        lo_idx   = CH_W'(i);
        if (i >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_idx   = CH_W'(i);
        end
      end
    end
  end

  assign win  = hi_found ? hi_idx : lo_idx;
  assign load = (~valid_q | evt.evt_ready) & lo_found;

  always_comb begin
    grant   = '0;
    rr_d    = rr_q;
    ch_d    = ch_q;
    valid_d = valid_q & ~evt.evt_ready;
    if (load) begin
      grant      = N_CH'(1) << win;
      ch_d       = win;
      valid_d    = 1'b1;
      rr_d       = (win == CH_W'(N_CH - 1)) ? '0 : win + CH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the event/arbitration rules.
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int CH_W = 2;
`ifdef EDGE_EVT_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk, rst, rdy, oclr;
  logic [N-1:0] sig, en, pend, ovf;
  int           n_run, n_fail, cyc;

  bit [N-1:0] m_prev, m_pend, m_ovf;
  bit         m_valid;
  int         m_ch, m_rr;

  edge_event_arbiter_if #(.N_CH(N)) evt_if ();
  assign evt_if.evt_ready = rdy;

  edge_event_arbiter #(.N_CH(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig),
    .ch_en  (en),
    .pend   (pend),
    .ovf    (ovf),
    .ovf_clr(oclr),
    .evt    (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] dut_vec();
    return {evt_if.evt_valid, evt_if.evt_ch, pend, ovf};
  endfunction

  function automatic logic [10:0] mdl_vec();
    return {m_valid, CH_W'(m_ch), m_pend, m_ovf};
  endfunction

  task automatic model_clear();
    m_prev = '0; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_ch = 0; m_rr = 0;
  endtask

  // One clock: evaluate the rules on the inputs present at the edge, then commit
  task automatic tick();
    bit [N-1:0] e, g, np, no;
    bit found, ld;
    int w;
    found = 1'b0; w = 0;
    for (int k = 0; k < N; k++)
      if (!found && m_pend[(m_rr + k) % N]) begin found = 1'b1; w = (m_rr + k) % N; end
    ld = found && (!m_valid || rdy);
    g  = '0;
    if (ld) g[w] = 1'b1;
    e  = sig & ~m_prev & en;
    np = en & (e | (m_pend & ~g));
    no = OVF_EN ? ((oclr ? '0 : m_ovf) | (e & m_pend & ~g)) : '0;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      m_prev  = sig;
      m_pend  = np;
      m_ovf   = no;
      m_valid = ld | (m_valid & ~rdy);
      if (ld) begin m_ch = w; m_rr = (w + 1) % N; end
    end
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; sig = '0; en = '1; rdy = 1'b1; oclr = 1'b0;
    model_clear();
    tick(); tick();
    n_run++;
    if (dut_vec() !== 11'd0) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), 11'd0);
    end
    rst = 1'b0;
    tick();
    n_run++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_fairness();
    logic [CH_W-1:0] exp_ch;
    for (int rep = 0; rep < 2; rep++) begin
      sig = '0; tick();
      sig = 4'hF; tick();
      for (int k = 0; k < N; k++) begin
        tick();
        exp_ch = CH_W'(k);
        n_run++;
        if ({evt_if.evt_valid, evt_if.evt_ch} !== {1'b1, exp_ch}) begin
          n_fail++; $display("FAIL fair_seq rep=%0d got=%b/%0d exp=1/%0d", rep, evt_if.evt_valid, evt_if.evt_ch, k);
        end
      end
      tick();
      n_run++;
      if (evt_if.evt_valid !== 1'b0) begin
        n_fail++; $display("FAIL fair_drain got=%b exp=0", evt_if.evt_valid);
      end
    end
    // one grant of channel 1 moves the pointer to 2
    sig = '0; tick();
    sig = 4'b0010; tick(); tick();
    sig = '0; tick();
    sig = 4'b1010; tick();
    tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL fair_rr2_first got=%b/%0d exp=1/3", evt_if.evt_valid, evt_if.evt_ch);
    end
    tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL fair_rr2_second got=%b/%0d exp=1/1", evt_if.evt_valid, evt_if.evt_ch);
    end
    n_run++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL fair_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_single_edge();
    sig = '0; rdy = 1'b1; tick(); tick();
    sig = 4'b0100; tick();
    n_run++;
    if ({evt_if.evt_valid, pend} !== {1'b0, 4'b0100}) begin
      n_fail++; $display("FAIL single_pend got=%b/%b exp=0/0100", evt_if.evt_valid, pend);
    end
    tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch, pend} !== {1'b1, 2'd2, 4'b0000}) begin
      n_fail++; $display("FAIL single_evt got=%b/%0d/%b exp=1/2/0000", evt_if.evt_valid, evt_if.evt_ch, pend);
    end
    tick();
    n_run++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drop got=%b exp=0", evt_if.evt_valid);
    end
  endtask

  task automatic test_backpressure();
    sig = '0; rdy = 1'b1; tick(); tick();
    rdy = 1'b0; sig = 4'b0011; tick(); tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_run++;
      if ({evt_if.evt_valid, evt_if.evt_ch, pend} !== {1'b1, 2'd0, 4'b0010}) begin
        n_fail++; $display("FAIL bp_hold k=%0d got=%b/%0d/%b exp=1/0/0010", k, evt_if.evt_valid, evt_if.evt_ch, pend);
      end
    end
    rdy = 1'b1; tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch, pend} !== {1'b1, 2'd1, 4'b0000}) begin
      n_fail++; $display("FAIL bp_next got=%b/%0d/%b exp=1/1/0000", evt_if.evt_valid, evt_if.evt_ch, pend);
    end
    tick();
    n_run++;
    if (evt_if.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain got=%b exp=0", evt_if.evt_valid);
    end
  endtask

  task automatic test_masking();
    int bad;
    sig = '0; rdy = 1'b1; en = '1; tick(); tick();
    en = 4'b0111; bad = 0;
    for (int k = 0; k < 6; k++) begin
      sig[3] = ~sig[3]; tick();
      if (pend[3] !== 1'b0 || evt_if.evt_valid !== 1'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin n_fail++; $display("FAIL mask_ch3 got=%0d bad cycles exp=0", bad); end
    rdy = 1'b0; sig = 4'b0001; tick(); tick();
    sig = 4'b0011; tick();
    n_run++;
    if (pend !== 4'b0010) begin n_fail++; $display("FAIL mask_set1 got=%b exp=0010", pend); end
    en = 4'b0101; tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch, pend} !== {1'b1, 2'd0, 4'b0000}) begin
      n_fail++; $display("FAIL mask_clr1 got=%b/%0d/%b exp=1/0/0000", evt_if.evt_valid, evt_if.evt_ch, pend);
    end
    rdy = 1'b1; tick();
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (evt_if.evt_valid !== 1'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin n_fail++; $display("FAIL mask_noevt1 got=%0d bad cycles exp=0", bad); end
    sig = 4'b1011; tick();
    en = '1; bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (pend !== 4'b0000 || evt_if.evt_valid !== 1'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin n_fail++; $display("FAIL mask_reen_level got=%0d bad cycles exp=0", bad); end
    sig = 4'b0011; tick();
    sig = 4'b1011; tick();
    n_run++;
    if (pend !== 4'b1000) begin n_fail++; $display("FAIL mask_reen_edge got=%b exp=1000", pend); end
    tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL mask_reen_evt got=%b/%0d exp=1/3", evt_if.evt_valid, evt_if.evt_ch);
    end
    sig = '0; tick(); tick();
  endtask

  task automatic test_overflow();
    logic [N-1:0] exp_ovf;
    exp_ovf = OVF_EN ? 4'b0010 : 4'b0000;
    sig = '0; rdy = 1'b1; oclr = 1'b0; tick(); tick();
    rdy = 1'b0; sig = 4'b0001; tick(); tick();
    sig = 4'b0011; tick();
    sig = 4'b0001; tick();
    sig = 4'b0011; tick();
    n_run++;
    if ({ovf, pend} !== {exp_ovf, 4'b0010}) begin
      n_fail++; $display("FAIL ovf_set got=%b/%b exp=%b/0010", ovf, pend, exp_ovf);
    end
    rdy = 1'b1; tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL ovf_evt1 got=%b/%0d exp=1/1", evt_if.evt_valid, evt_if.evt_ch);
    end
    tick();
    n_run++;
    if ({evt_if.evt_valid, ovf} !== {1'b0, exp_ovf}) begin
      n_fail++; $display("FAIL ovf_single got=%b/%b exp=0/%b", evt_if.evt_valid, ovf, exp_ovf);
    end
    oclr = 1'b1; tick(); oclr = 1'b0;
    n_run++;
    if (ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0000", ovf); end
    sig = '0; rdy = 1'b0; tick();
    sig = 4'b0001; tick(); tick();
    sig = 4'b0011; tick();
    sig = 4'b0001; tick();
    sig = 4'b0011; oclr = 1'b1; tick(); oclr = 1'b0;
    n_run++;
    if (ovf !== exp_ovf) begin n_fail++; $display("FAIL ovf_set_wins got=%b exp=%b", ovf, exp_ovf); end
    oclr = 1'b1; rdy = 1'b1; sig = '0; tick(); oclr = 1'b0;
    tick(); tick(); tick();
    n_run++;
    if (dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL ovf_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_async_reset();
    rdy = 1'b0; sig = '0; tick();
    sig = 4'b0011; tick(); tick();
    n_run++;
    if (!(evt_if.evt_valid === 1'b1 && pend !== 4'b0000)) begin
      n_fail++; $display("FAIL arst_pre got=%b/%b exp=1/nonzero", evt_if.evt_valid, pend);
    end
    #2 rst = 1'b1;
    #1;
    model_clear();
    n_run++;
    if (dut_vec() !== 11'd0) begin
      n_fail++; $display("FAIL arst_async got=%h exp=%h", dut_vec(), 11'd0);
    end
    sig = 4'b0001; rdy = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_run++;
    if ({evt_if.evt_valid, pend} !== {1'b0, 4'b0001}) begin
      n_fail++; $display("FAIL arst_edge got=%b/%b exp=0/0001", evt_if.evt_valid, pend);
    end
    tick();
    n_run++;
    if ({evt_if.evt_valid, evt_if.evt_ch} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL arst_evt got=%b/%0d exp=1/0", evt_if.evt_valid, evt_if.evt_ch);
    end
    sig = '0; tick(); tick();
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    for (int k = 0; k < 600; k++) begin
      sig  = N'($urandom);
      en   = N'($urandom | $urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      oclr = ($urandom_range(0, 7) == 0);
      tick();
      n_run++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++;
        if (shown < 10) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), mdl_vec());
        shown++;
      end
    end
    oclr = 1'b0; en = '1; rdy = 1'b1;
  endtask

  initial begin
    n_run = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; sig = '0; en = '1; rdy = 1'b1; oclr = 1'b0;
    test_reset();
    test_fairness();
    test_single_edge();
    test_backpressure();
    test_masking();
    test_overflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel rising-edge event collector and round-robin scheduler. It detects rising edges on `N_CH` asynchronous-domain-free (already synchronous) level inputs and latches each edge as a pending event. It serialises the pending events to a single downstream consumer over a valid/ready handshake, one channel index per transfer. It sits between the per-signal edge-detection stage and the interrupt/event-logging logic, and shares that single consumer port fairly between channels.

## Interface
- `N_CH`, default 4: number of input channels, range 2..16.
- `CH_W`, default `$clog2(N_CH)`: width of the channel index. Derived; do not override.
- `clk` input, 1 bit: clock; all logic on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `sig_in` input, `N_CH` bits: level inputs, one per channel, synchronous to `clk`.
- `ch_en` input, `N_CH` bits: per-channel enable. When low, edges on that channel are masked and its pending flag is cleared.
- `evt_valid` output, 1 bit: an event is presented on `evt_ch`.
- `evt_ready` input, 1 bit: the consumer accepts the event when `evt_valid & evt_ready`.
- `evt_ch` output, `CH_W` bits: index of the channel whose edge is presented.
- `pend` output, `N_CH` bits: current pending flags, registered.
- `ovf` output, `N_CH` bits: sticky per-channel overflow flags; tied 0 when the feature is compiled out.
- `ovf_clr` input, 1 bit: clears all `ovf` bits.

## Operation
- Per channel, a `prev[i]` register holds the last-cycle value of `sig_in[i]`. Edge: `e[i] = sig_in[i] & ~prev[i] & ch_en[i]`. `prev` always tracks `sig_in`, including while the channel is disabled.
- Pending update per cycle: `pend[i] <= ch_en[i] & (e[i] | (pend[i] & ~grant[i]))`.
  - A new edge in the same cycle as a grant of that channel leaves `pend[i]` set, because that edge is a new event.
- Output register (`evt_valid`, `evt_ch`) behaves as a one-entry skid.
  - It loads when `~evt_valid | evt_ready` and `|pend` is true.
  - It holds `evt_valid`/`evt_ch` stable while `evt_valid & ~evt_ready`.
  - It drops `evt_valid` when accepted with nothing pending.
- Arbitration: round-robin over the registered `pend`, searching from `rr_ptr` upward with wrap-around. The lowest index at or above `rr_ptr` wins; otherwise the lowest index overall wins.
  - On load, `grant[i]=1` for the winner, `evt_ch <= i`, and `rr_ptr <= (i+1) mod N_CH`.
  - `rr_ptr` is unchanged when there is no load.
- Disabling a channel while its event sits in the output register does not retract that event. It is still delivered.
- Reset values: `prev`=0, `pend`=0, `ovf`=0, `evt_valid`=0, `evt_ch`=0, `rr_ptr`=0.
  - An input that is high when `rst` deasserts registers an edge on the first clock.
- Reset mid-transfer drops the presented event and all pending events immediately (asynchronously).

## Timing
- An edge sampled at clock edge t sets `pend` at t. With the output register free, `evt_valid`/`evt_ch` are updated at t+1, giving 1 cycle of `sig_in`-to-`evt_valid` latency after the sampling edge.
- Sustained throughput is 1 event per cycle when `evt_ready` is held high.
- Back-to-back handshake: accept at t and load the next winner at t, with no bubble.
- With all channels pending continuously, each channel is granted at least once every `N_CH` transfers.
- Multiple edges on one channel while it is pending merge into one event.

## Configuration
- `EDGE_EVT_OVERFLOW_EN` defined: `ovf[i]` sets when `e[i] & pend[i] & ~grant[i]`, meaning an edge is lost by merging.
  - `ovf[i]` stays set until `ovf_clr`.
  - Set wins over a simultaneous `ovf_clr`.
  - `ovf` is cleared by `rst`.
- `EDGE_EVT_OVERFLOW_EN` undefined: `ovf` is driven constant 0, `ovf_clr` is ignored, and no overflow registers are synthesised.

## Test plan
- Single edge: `N_CH`=4, `ch_en`=4'hF, `evt_ready`=1, `sig_in[2]` 0→1 at edge t. Expect `pend`=4'b0100 after t, then `evt_valid`=1 with `evt_ch`=2 after t+1. `pend`=0 and `evt_valid` drops after t+2.
- Fairness: `sig_in` 0→4'hF simultaneously, `evt_ready`=1. Expect `evt_ch` sequence 0,1,2,3 on consecutive cycles. Then re-pulse 4'hF with `rr_ptr`=0 and get 0,1,2,3 again. Pulse channels 1 and 3 with `rr_ptr`=2 and get 3 then 1.
- Backpressure: hold `evt_ready`=0 for 5 cycles with channels 0 and 1 pending. `evt_valid`=1 and `evt_ch`=0 stay stable, and `pend`=4'b0010. Raise `evt_ready` and get 0, then 1, on consecutive cycles.
- Masking: `ch_en[3]`=0 with `sig_in[3]` toggling, so no event and no `pend[3]`. Set `pend[1]`, then drop `ch_en[1]`, so `pend[1]` clears next cycle and no event for 1 is issued. Re-enable `ch_en[3]` while `sig_in[3]`=1, so no event is produced until the next 0→1.
- Overflow (macro defined): `evt_ready`=0, `evt_valid` holding channel 0, and `sig_in[1]` pulses twice. Expect `ovf`=4'b0010 and a single event for 1 later. Pulse `ovf_clr` and get `ovf`=0. Edge coincident with `ovf_clr` leaves the bit set. With the macro undefined, `ovf` stays 0.
- Async reset: assert `rst` mid-stream with `evt_valid`=1 and `pend`≠0. Outputs go to 0 without a clock edge. After release with `sig_in[0]`=1, expect an event for channel 0 two cycles later.
